uart_rx_ext: RTL
================

Name: uart_rx_ext

Overview:
Parametrised, oversampling UART receiver. Data width, oversampling ratio and stop length are set by parameters; parity mode is selected at runtime.
- Adds an input synchroniser, start-glitch rejection, parity/framing/break detection and a ready/valid output register with overrun reporting.
- Sits between the pad-side rx line plus the shared baud-tick generator and a FIFO or consumer logic.

Parameters:
DBIT, 8, data bits per frame (legal 5..9)
OVS, 16, s_tick periods per bit (even, >=8)
SB_TICK, 16, s_tick periods in stop phase (16/24/32 = 1/1.5/2 stop bits; >=4)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
rx  in  1  serial line, asynchronous, idle high
s_tick  in  1  one-clk enable pulse at OVS x baud
par_mode  in  2  00/11 none, 01 even, 10 odd
dout  out  DBIT  received word, LSB first on the line
dout_valid  out  1  dout and flags hold an unconsumed word
dout_ready  in  1  consumer accepts the word when high with dout_valid
par_err  out  1  parity mismatch for the held word
frame_err  out  1  stop bit sampled low for the held word
break_det  out  1  held word is a break: all data, parity (if any) and stop bits sampled 0
overrun  out  1  one-clk pulse: a completed word was dropped

Behaviour:
- Reset (async, any state, including mid-frame):
  - state=IDLE, counters 0.
  - dout=0, dout_valid=0, all flags 0, synchroniser flops=1.
- rx passes through a 2-flop synchroniser giving rx_s; all decisions use rx_s (2 clk latency).
- The s counter is 4+ bits wide, sized for max(OVS, SB_TICK). The bit counter is sized for DBIT.
- IDLE: rx_s==0 -> START, s=0. Latch par_mode for the whole frame.
- START, on each s_tick:
  - rx_s==1 while s<OVS/2-1 -> IDLE (glitch reject, nothing reported).
  - s==OVS/2-1 with rx_s==0 -> DATA, s=0, n=0.
  - Otherwise s++.
- DATA, on s_tick: at s==OVS-1 sample the bit, shift b={bit,b[DBIT-1:1]}, s=0.
  - After bit DBIT-1: -> PARITY if latched mode is 01/10, else -> STOP.
  - Otherwise s++.
- PARITY: sample at s==OVS-1, then -> STOP.
  - perr = (^b ^ bit) != 0 for even parity.
  - perr = (^b ^ bit) != 1 for odd parity.
- STOP: sample at s==SB_TICK-1, producing the word. Then:
  - If the stop bit sampled 1 -> IDLE.
  - If it sampled 0 -> WAIT_HIGH, which stays until rx_s==1, then -> IDLE. This prevents re-triggering during a break.
- Word completion (cycle of the final stop sample):
  - On the next clk, dout<=b, par_err<=perr, frame_err<=(stop==0), break_det<=frame_err && b==0 && parity sample==0 (when present), dout_valid<=1.
  - Latency: dout_valid rises 1 clk after the final stop s_tick.
  - If dout_valid=1 and dout_ready=0 in the completion cycle: the new word is discarded, held word and flags are unchanged, overrun pulses 1 clk.
  - If dout_valid=1 and dout_ready=1 in the same cycle: the old word is consumed, the new word loads, no overrun.
- Handshake:
  - dout_valid && dout_ready with no completion -> dout_valid<=0 next clk.
  - dout and the flags hold their values until they are replaced.
  - dout_ready is ignored while dout_valid=0.
- s_tick low: all counters hold. The FSM still reacts to rx_s in IDLE and WAIT_HIGH.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: data, parity and stop bits are decided by a 2-of-3 majority of rx_s sampled at ticks s==N-3, N-2, N-1 (N=OVS, or SB_TICK for stop). The decision takes effect at N-1, so timing is identical to the non-majority build.
- Undefined: single sample at N-1; no extra registers.

Test Plan:
- OVS=16, s_tick every clk, par_mode=00: send 0xA5 with 1 stop -> dout=0xA5, dout_valid high 1 clk after the last stop tick, all flags 0.
- par_mode=01: send 0x07 with parity bit 0 -> par_err=1. Resend with parity bit 1 -> par_err=0. par_mode=10 inverts both results.
- Hold rx low for 4 clk then high, from IDLE -> no word produced, FSM back in IDLE.
- Hold rx low for 12 bit times -> one word: dout=0, frame_err=1, break_det=1. No second word until rx returns high and a new start bit arrives.
- Two frames 0x11 then 0x22 with dout_ready=0 -> dout stays 0x11, overrun pulses once at the second completion. Repeat with dout_ready=1 in the completion cycle -> dout=0x22, no overrun.
- Assert reset mid-DATA -> outputs 0 immediately. The next clean frame 0x3C is received correctly. With UART_RX_MAJORITY_EN, a 1-clk glitch at mid-bit does not corrupt 0x3C.

Source files
------------

// File: rtl/uart_rx_ext.sv
// ---------------------------------------------------------------------------
// uart_rx_ext : oversampling UART receiver with ready/valid output register.
//
// The rx line passes through a two-flop synchroniser. Frames are timed by
// s_tick, which pulses OVS times per bit. The start bit is checked at
// mid-bit, so low glitches shorter than half a bit are rejected. Each data
// bit, and the optional parity bit, is sampled at the end of its OVS-tick
// window. The stop bit is sampled after SB_TICK ticks. A stop bit sampled
// low parks the FSM in WAIT_HIGH until the line goes idle again, so a held
// break yields exactly one word.
//
// Parameters:
//   DBIT    data bits per frame (5..9)
//   OVS     s_tick periods per bit (even, >= 8)
//   SB_TICK s_tick periods in the stop phase (>= 4)
//
// Optional build macro:
//   UART_RX_MAJORITY_EN  each bit is decided by a 2-of-3 vote of rx_s taken
//                        at ticks N-3, N-2 and N-1 of its window. Timing is
//                        unchanged.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   rx           asynchronous serial input, idle high
//   s_tick       one-clk enable pulse at OVS x baud
//   par_mode     00/11 none, 01 even, 10 odd (latched at the start bit)
//   dout         received word (first bit on the line is dout[0])
//   dout_valid   dout and flags hold an unconsumed word
//   dout_ready   consumer accepts the word when high with dout_valid
//   par_err      parity mismatch for the held word
//   frame_err    stop bit sampled low for the held word
//   break_det    held word is a break (all bits sampled 0)
//   overrun      one-clk pulse: a completed word was dropped
// ---------------------------------------------------------------------------
module uart_rx_ext #(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    input  logic [1:0]      par_mode,
    output logic [DBIT-1:0] dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            par_err,
    output logic            frame_err,
    output logic            break_det,
    output logic            overrun
);

    localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW   = ($clog2(SMAX) > 4) ? $clog2(SMAX) : 4;
    localparam int NW   = $clog2(DBIT);

    localparam logic [SW-1:0] HALF_END = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] BIT_END  = SW'(OVS - 1);
    localparam logic [SW-1:0] STOP_END = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] LAST_BIT = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    state_t          state;
    logic [1:0]      sync_r;
    logic [SW-1:0]   s_r;
    logic [NW-1:0]   n_r;
    logic [DBIT-1:0] b_r;
    logic            has_par_r;
    logic            par_odd_r;
    logic            par_bit_r;
    logic            perr_r;

    logic            rx_s;
    logic            bit_s;
    logic            perr_s;
    logic            brk_s;
    logic            done_s;
    logic [SW-1:0]   win_end_s;

    assign rx_s = sync_r[1];

    // Two-flop synchroniser; flops reset to the idle-high line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx};
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_r;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Keep the two early votes (ticks N-3 and N-2) of the current bit window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            maj_r <= 2'b00;
        end else if (s_tick &&
                     (state == ST_DATA || state == ST_PARITY || state == ST_STOP) &&
                     (s_r == win_end_s - SW'(2) || s_r == win_end_s - SW'(1))) begin
            maj_r <= {maj_r[0], rx_s};
        end else begin
            maj_r <= maj_r;
        end
    end
`endif

    // Bit decision, parity check and word-completion strobes.
    always_comb begin
        win_end_s = (state == ST_STOP) ? STOP_END : BIT_END;
`ifdef UART_RX_MAJORITY_EN
        bit_s     = maj3(maj_r[1], maj_r[0], rx_s);
`else
        bit_s     = rx_s;
`endif
        // Even parity expects an even count of ones; odd parity flips that.
        perr_s    = (^b_r) ^ bit_s ^ par_odd_r;
        brk_s     = !bit_s && (b_r == '0) && !(has_par_r && par_bit_r);
        done_s    = s_tick && (state == ST_STOP) && (s_r == STOP_END);
    end

    // Receive FSM, counters and the ready/valid output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            s_r        <= '0;
            n_r        <= '0;
            b_r        <= '0;
            has_par_r  <= 1'b0;
            par_odd_r  <= 1'b0;
            par_bit_r  <= 1'b0;
            perr_r     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            par_err    <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            // A finished word only loads if the register is free or being
            // consumed in this same cycle; otherwise it is dropped.
            if (done_s) begin
                if (dout_valid && !dout_ready) begin
                    overrun <= 1'b1;
                end else begin
                    dout       <= b_r;
                    par_err    <= has_par_r && perr_r;
                    frame_err  <= !bit_s;
                    break_det  <= brk_s;
                    dout_valid <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state     <= ST_START;
                        s_r       <= '0;
                        has_par_r <= (par_mode == 2'b01) || (par_mode == 2'b10);
                        par_odd_r <= (par_mode == 2'b10);
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        // s never passes HALF_END here, so a high line is
                        // always a glitch.
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else if (s_r == HALF_END) begin
                            state <= ST_DATA;
                            s_r   <= '0;
                            n_r   <= '0;
                        end else begin
                            s_r <= s_r + SW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (s_r == BIT_END) begin
                            s_r <= '0;
                            b_r <= {bit_s, b_r[DBIT-1:1]};
                            if (n_r == LAST_BIT) begin
                                state <= has_par_r ? ST_PARITY : ST_STOP;
                            end else begin
                                n_r <= n_r + NW'(1);
                            end
                        end else begin
                            s_r <= s_r + SW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (s_tick) begin
                        if (s_r == BIT_END) begin
                            s_r       <= '0;
                            par_bit_r <= bit_s;
                            perr_r    <= perr_s;
                            state     <= ST_STOP;
                        end else begin
                            s_r <= s_r + SW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (s_tick) begin
                        if (s_r == STOP_END) begin
                            s_r   <= '0;
                            state <= bit_s ? ST_IDLE : ST_WAIT_HIGH;
                        end else begin
                            s_r <= s_r + SW'(1);
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    s_r   <= '0;
                    n_r   <= '0;
                end
            endcase
        end
    end

endmodule
